rx_packet_parser: RTL and testbench
===================================

Name: rx_packet_parser

Overview:
Byte-to-packet framing engine behind the UART byte receiver. Consumes one byte per rx_done strobe and parses frames of the form [SYNC] CMD LEN[1..2 bytes] DATA[LEN] CHK. Payload bytes are streamed into a downstream write port (RAM/FIFO). Validated command and length are presented through a valid/ack handshake. Generalises the single-format 8-bit-length parser:
- configurable length width
- selectable checksum algorithm
- optional sync byte
- error reporting
- back-pressure

Parameters:
MAX_LEN, 256, largest accepted payload length in bytes; ADDR_W = $clog2(MAX_LEN)
LEN_BYTES, 1, length field size in bytes (1 or 2; 2 = big-endian, MSB first)
CHK_MODE, 0, 0 = inverted 8-bit sum; 1 = CRC-8 (poly 0x07, init 0x00, no reflection, no final xor)
SYNC_EN, 0, 1 = frame must start with SYNC_BYTE
SYNC_BYTE, 8'hA5, sync value when SYNC_EN = 1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_data  in  8  received byte, valid when rx_done = 1
rx_done  in  1  one-cycle byte strobe
timeout  in  1  inter-byte timeout pulse from byte receiver
pck_valid  out  1  good packet available; held until pck_ack
pck_ack  in  1  consumer releases packet
cmd_rx  out  8  command byte of last good packet
len_rx  out  8*LEN_BYTES  payload length of last good packet
pck_err  out  1  one-cycle error pulse
err_code  out  3  1 = checksum, 2 = length, 3 = timeout, 4 = overrun; held until next pck_err
wr_data  out  8  payload byte
wr_addr  out  ADDR_W  payload byte index
we  out  1  one-cycle write strobe
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset = 0, async): state IDLE; all outputs 0; checksum accumulator 0; byte counter 0.
- States: IDLE, CMD, LEN_H, LEN_L, DATA, CHK, HOLD. Transitions occur only on rx_done except where noted.
- IDLE:
  - SYNC_EN = 1: byte == SYNC_BYTE -> CMD; any other byte is ignored silently.
  - SYNC_EN = 0: the byte is latched as the command byte; go to LEN_H if LEN_BYTES = 2, else LEN_L.
- CMD: latch the command byte; go to LEN_H if LEN_BYTES = 2, else LEN_L.
- LEN_H -> LEN_L.
- LEN_L, length check:
  - length > MAX_LEN -> pck_err with err_code = 2, return to IDLE.
  - length == 0 -> CHK.
  - otherwise -> DATA.
- DATA:
  - Each byte produces we = 1, wr_data = byte, wr_addr = index (0..LEN-1), one cycle after rx_done.
  - After byte LEN-1 -> CHK.
- CHK, checksum comparison:
  - Checksum covers CMD, LEN and DATA bytes; the sync byte is excluded.
  - Mode 0 expects ~(sum mod 256). Mode 1 expects the CRC-8 value.
  - Match: latch cmd_rx/len_rx, pck_valid = 1 the cycle after rx_done, go to HOLD.
  - Mismatch: pck_err with err_code = 1, return to IDLE.
- HOLD:
  - pck_valid stays high; cmd_rx/len_rx stay stable.
  - pck_ack -> pck_valid = 0 next cycle, go to IDLE.
  - rx_done without pck_ack: byte dropped, pck_err with err_code = 4, stay in HOLD.
  - pck_ack and rx_done in the same cycle: ack wins; the byte is processed as an IDLE byte.
- timeout:
  - In any state other than IDLE/HOLD: pck_err with err_code = 3, return to IDLE, accumulator cleared.
  - Ignored in IDLE/HOLD.
  - timeout and rx_done in the same cycle outside IDLE/HOLD: timeout wins, byte discarded.
- Failed packets: payload bytes already written remain in the sink. The consumer must only trust data while pck_valid = 1.
- Checksum accumulator and byte counter clear on every return to IDLE. The CRC is updated bytewise, one byte per cycle (combinational 8-step update).
- Latency: rx_done at cycle N -> we / pck_valid / pck_err at N+1.

Decomposition:
- Package rx_packet_pkg holds:
  - state enum
  - err_code localparams (ERR_NONE = 0, ERR_CHK = 1, ERR_LEN = 2, ERR_TMO = 3, ERR_OVR = 4)
  - CRC-8 polynomial constant
  - function crc8_byte(crc, byte)
- One sub-module: rx_chk_accum, with clear/enable/byte inputs and an 8-bit value output, parametrised by CHK_MODE.

Test Plan:
- Good frame, defaults: 74 03 5A 18 F0 26 -> we at addr 0/1/2 with data 5A/18/F0; pck_valid = 1, cmd_rx = 74, len_rx = 3; ack clears pck_valid.
- Checksum error: same frame with last byte 27 -> three we pulses, pck_err with err_code = 1, pck_valid stays 0, state IDLE.
- CRC mode, CHK_MODE = 1: 01 00 15 -> pck_valid, len_rx = 0, no we. With last byte 14 -> err_code = 1.
- LEN_BYTES = 2, MAX_LEN = 256: 10 01 01 (len 257) -> err_code = 2 after the 3rd byte. 10 00 02 AA BB chk -> good, wr_addr 0..1.
- Timeout and sync:
  - SYNC_EN = 1: FF A5 74 01 33 chk -> FF ignored, good packet.
  - Timeout after the 33 byte -> err_code = 3, then a new frame parses cleanly.
- HOLD overrun / reset:
  - Byte during HOLD -> err_code = 4, pck_valid stays 1, cmd_rx unchanged.
  - pck_ack with a simultaneous A5 -> frame restarts.
  - reset = 0 mid-DATA -> all outputs 0 immediately.

Source files
------------

// File: rtl/rx_packet_pkg.sv
// Shared types, error codes and CRC-8 helper for the rx packet parser.
package rx_packet_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_LEN_H = 3'd2,
      ST_LEN_L = 3'd3,
      ST_DATA  = 3'd4,
      ST_CHK   = 3'd5,
      ST_HOLD  = 3'd6
   } rx_state_t;

   localparam logic [2:0] ERR_NONE = 3'd0;
   localparam logic [2:0] ERR_CHK  = 3'd1;
   localparam logic [2:0] ERR_LEN  = 3'd2;
   localparam logic [2:0] ERR_TMO  = 3'd3;
   localparam logic [2:0] ERR_OVR  = 3'd4;

   // CRC-8: x^8 + x^2 + x + 1, init 0x00, MSB first, no final xor.
   localparam logic [7:0] CRC8_POLY = 8'h07;

   // Advance the CRC by one full byte (eight shift steps unrolled).
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/rx_packet_parser_if.sv
// Bus bundle between the byte receiver / consumer / payload sink and the parser.
//
// Handshake semantics:
//   rx_done  : one-cycle strobe, rx_data is valid only in that cycle; there is
//              no ready, a byte offered while the parser is holding a packet is
//              dropped and reported as an overrun.
//   pck_valid: rises the cycle after the checksum byte and stays high with
//              cmd_rx/len_rx stable until the cycle after pck_ack is seen high.
//   we       : one-cycle strobe, wr_data/wr_addr valid only in that cycle.
//   pck_err  : one-cycle strobe, err_code holds its value until the next pck_err.
interface rx_packet_parser_if #(
   parameter int LEN_BYTES = 1,
   parameter int ADDR_W    = 8
);
   import rx_packet_pkg::*;

   logic [7:0]             rx_data;
   logic                   rx_done;
   logic                   timeout;
   logic                   pck_ack;
   logic                   pck_valid;
   logic [7:0]             cmd_rx;
   logic [8*LEN_BYTES-1:0] len_rx;
   logic                   pck_err;
   logic [2:0]             err_code;
   logic [7:0]             wr_data;
   logic [ADDR_W-1:0]      wr_addr;
   logic                   we;
   logic                   busy;
   rx_state_t              state_dbg;

   modport master (
      input  rx_data, rx_done, timeout, pck_ack,
      output pck_valid, cmd_rx, len_rx, pck_err, err_code,
             wr_data, wr_addr, we, busy, state_dbg
   );

   modport slave (
      output rx_data, rx_done, timeout, pck_ack,
      input  pck_valid, cmd_rx, len_rx, pck_err, err_code,
             wr_data, wr_addr, we, busy, state_dbg
   );

endinterface

// File: rtl/rx_chk_accum.sv
// Running checksum over the frame bytes. value is the check byte the frame
// must end with: inverted sum in mode 0, CRC-8 in mode 1.
module rx_chk_accum
   import rx_packet_pkg::*;
#(
   parameter int CHK_MODE = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       en,
   input  logic [7:0] data,
   output logic [7:0] value
);

   logic [7:0] acc_q;
   logic [7:0] base;
   logic [7:0] upd;

   // Clear-then-accumulate so a byte arriving on the clearing cycle starts a fresh sum.
   always_comb begin
      base = clear ? 8'h00 : acc_q;
      if (CHK_MODE == 1) upd = crc8_byte(base, data);
      else               upd = base + data;
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     acc_q <= 8'h00;
      else if (en)    acc_q <= upd;
      else if (clear) acc_q <= 8'h00;
   end

   assign value = (CHK_MODE == 1) ? acc_q : ~acc_q;

endmodule

// File: rtl/rx_packet_parser.sv
// Byte-to-packet framing engine: [SYNC] CMD LEN DATA CHK.
module rx_packet_parser
   import rx_packet_pkg::*;
#(
   parameter int         MAX_LEN   = 256,
   parameter int         LEN_BYTES = 1,
   parameter int         CHK_MODE  = 0,
   parameter bit         SYNC_EN   = 1'b0,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input logic                clk,
   input logic                reset,
   rx_packet_parser_if.master bus
);

   localparam int          ADDR_W    = $clog2(MAX_LEN);
   localparam int          LW        = 8 * LEN_BYTES;
   localparam int          CW        = (LW > ADDR_W) ? LW : ADDR_W;
   localparam logic [31:0] MAX_LEN_W = 32'(MAX_LEN);
   localparam rx_state_t   LEN_FIRST = (LEN_BYTES == 2) ? ST_LEN_H : ST_LEN_L;

   rx_state_t     state;
   logic [7:0]    cmd_q;
   logic [7:0]    len_hi;
   logic [LW-1:0] len_q;
   logic [CW-1:0] cnt;

   logic          tmo_hit;
   logic          ack_hit;
   logic          idle_like;
   logic          byte_ev;
   logic [LW-1:0] len_full;
   logic          len_bad;
   logic          last_byte;
   logic          acc_en;
   logic          acc_clr;
   logic [7:0]    chk_value;

   // Event decode and checksum accumulator control.
   always_comb begin
      tmo_hit   = bus.timeout && (state != ST_IDLE) && (state != ST_HOLD);
      ack_hit   = (state == ST_HOLD) && bus.pck_ack;
      idle_like = (state == ST_IDLE) || ack_hit;
      byte_ev   = bus.rx_done && !tmo_hit;
      len_full  = LW'({len_hi, bus.rx_data});
      len_bad   = 32'(len_full) > MAX_LEN_W;
      last_byte = (cnt + CW'(1)) == CW'(len_q);
      acc_en    = 1'b0;
      acc_clr   = idle_like || tmo_hit;
      if (byte_ev && idle_like) begin
         acc_en = !SYNC_EN;
      end else if (byte_ev) begin
         case (state)
            ST_CMD, ST_LEN_H, ST_DATA: acc_en = 1'b1;
            ST_LEN_L: begin
               if (len_bad) acc_clr = 1'b1;
               else         acc_en  = 1'b1;
            end
            ST_CHK:  acc_clr = 1'b1;
            default: ;
         endcase
      end
   end

   rx_chk_accum #(.CHK_MODE(CHK_MODE)) u_chk (
      .clk   (clk),
      .reset (reset),
      .clear (acc_clr),
      .en    (acc_en),
      .data  (bus.rx_data),
      .value (chk_value)
   );

   // Framing FSM with registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         cmd_q         <= 8'h00;
         len_hi        <= 8'h00;
         len_q         <= '0;
         cnt           <= '0;
         bus.pck_valid <= 1'b0;
         bus.cmd_rx    <= 8'h00;
         bus.len_rx    <= '0;
         bus.pck_err   <= 1'b0;
         bus.err_code  <= ERR_NONE;
         bus.wr_data   <= 8'h00;
         bus.wr_addr   <= '0;
         bus.we        <= 1'b0;
      end else begin
         bus.we      <= 1'b0;
         bus.pck_err <= 1'b0;
         if (tmo_hit) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bus.pck_err  <= 1'b1;
            bus.err_code <= ERR_TMO;
         end else if (idle_like) begin
            cnt <= '0;
            if (ack_hit) begin
               bus.pck_valid <= 1'b0;
               state         <= ST_IDLE;
            end
            if (bus.rx_done) begin
               if (SYNC_EN) begin
                  if (bus.rx_data == SYNC_BYTE) state <= ST_CMD;
               end else begin
                  cmd_q <= bus.rx_data;
                  state <= LEN_FIRST;
               end
            end
         end else if (bus.rx_done) begin
            case (state)
               ST_CMD: begin
                  cmd_q <= bus.rx_data;
                  state <= LEN_FIRST;
               end
               ST_LEN_H: begin
                  len_hi <= bus.rx_data;
                  state  <= ST_LEN_L;
               end
               ST_LEN_L: begin
                  if (len_bad) begin
                     state        <= ST_IDLE;
                     bus.pck_err  <= 1'b1;
                     bus.err_code <= ERR_LEN;
                  end else begin
                     len_q <= len_full;
                     state <= (len_full == '0) ? ST_CHK : ST_DATA;
                  end
               end
               ST_DATA: begin
                  bus.we      <= 1'b1;
                  bus.wr_data <= bus.rx_data;
                  bus.wr_addr <= cnt[ADDR_W-1:0];
                  cnt         <= cnt + CW'(1);
                  if (last_byte) state <= ST_CHK;
               end
               ST_CHK: begin
                  cnt <= '0;
                  if (bus.rx_data == chk_value) begin
                     bus.cmd_rx    <= cmd_q;
                     bus.len_rx    <= len_q;
                     bus.pck_valid <= 1'b1;
                     state         <= ST_HOLD;
                  end else begin
                     state        <= ST_IDLE;
                     bus.pck_err  <= 1'b1;
                     bus.err_code <= ERR_CHK;
                  end
               end
               ST_HOLD: begin
                  bus.pck_err  <= 1'b1;
                  bus.err_code <= ERR_OVR;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.busy      = (state != ST_IDLE);
   assign bus.state_dbg = state;

endmodule

// File: tb/tb_rx_packet_parser.sv
// Directed bench for rx_packet_parser: four instances cover the default,
// CRC, two-byte-length and sync-byte configurations; sel routes stimulus.
module tb_rx_packet_parser;
   import rx_packet_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b0;
   logic       timeout = 1'b0;
   logic       pck_ack = 1'b0;
   int         sel = 0;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [15:0] exp_q[$];

   // clock
   always #5 clk = ~clk;

   rx_packet_parser_if #(.LEN_BYTES(1), .ADDR_W(8)) if_def ();
   rx_packet_parser_if #(.LEN_BYTES(1), .ADDR_W(8)) if_crc ();
   rx_packet_parser_if #(.LEN_BYTES(2), .ADDR_W(8)) if_len2 ();
   rx_packet_parser_if #(.LEN_BYTES(1), .ADDR_W(8)) if_sync ();

   assign if_def.rx_data  = rx_data;
   assign if_def.rx_done  = rx_done && (sel == 0);
   assign if_def.timeout  = timeout && (sel == 0);
   assign if_def.pck_ack  = pck_ack && (sel == 0);
   assign if_crc.rx_data  = rx_data;
   assign if_crc.rx_done  = rx_done && (sel == 1);
   assign if_crc.timeout  = timeout && (sel == 1);
   assign if_crc.pck_ack  = pck_ack && (sel == 1);
   assign if_len2.rx_data = rx_data;
   assign if_len2.rx_done = rx_done && (sel == 2);
   assign if_len2.timeout = timeout && (sel == 2);
   assign if_len2.pck_ack = pck_ack && (sel == 2);
   assign if_sync.rx_data = rx_data;
   assign if_sync.rx_done = rx_done && (sel == 3);
   assign if_sync.timeout = timeout && (sel == 3);
   assign if_sync.pck_ack = pck_ack && (sel == 3);

   rx_packet_parser #(.MAX_LEN(256), .LEN_BYTES(1), .CHK_MODE(0), .SYNC_EN(1'b0), .SYNC_BYTE(8'hA5))
      u_def (.clk(clk), .reset(reset), .bus(if_def));
   rx_packet_parser #(.MAX_LEN(256), .LEN_BYTES(1), .CHK_MODE(1), .SYNC_EN(1'b0), .SYNC_BYTE(8'hA5))
      u_crc (.clk(clk), .reset(reset), .bus(if_crc));
   rx_packet_parser #(.MAX_LEN(256), .LEN_BYTES(2), .CHK_MODE(0), .SYNC_EN(1'b0), .SYNC_BYTE(8'hA5))
      u_len2 (.clk(clk), .reset(reset), .bus(if_len2));
   rx_packet_parser #(.MAX_LEN(256), .LEN_BYTES(1), .CHK_MODE(0), .SYNC_EN(1'b1), .SYNC_BYTE(8'hA5))
      u_sync (.clk(clk), .reset(reset), .bus(if_sync));

   // Observed outputs of the selected instance.
   logic        obs_valid, obs_err, obs_we, obs_busy;
   logic [2:0]  obs_code, obs_state;
   logic [7:0]  obs_cmd, obs_wdata, obs_waddr;
   logic [15:0] obs_len;

   always_comb begin
      obs_valid = if_def.pck_valid; obs_err = if_def.pck_err; obs_we = if_def.we;
      obs_busy = if_def.busy; obs_code = if_def.err_code; obs_state = if_def.state_dbg;
      obs_cmd = if_def.cmd_rx; obs_wdata = if_def.wr_data; obs_waddr = if_def.wr_addr;
      obs_len = {8'h00, if_def.len_rx};
      case (sel)
         1: begin
            obs_valid = if_crc.pck_valid; obs_err = if_crc.pck_err; obs_we = if_crc.we;
            obs_busy = if_crc.busy; obs_code = if_crc.err_code; obs_state = if_crc.state_dbg;
            obs_cmd = if_crc.cmd_rx; obs_wdata = if_crc.wr_data; obs_waddr = if_crc.wr_addr;
            obs_len = {8'h00, if_crc.len_rx};
         end
         2: begin
            obs_valid = if_len2.pck_valid; obs_err = if_len2.pck_err; obs_we = if_len2.we;
            obs_busy = if_len2.busy; obs_code = if_len2.err_code; obs_state = if_len2.state_dbg;
            obs_cmd = if_len2.cmd_rx; obs_wdata = if_len2.wr_data; obs_waddr = if_len2.wr_addr;
            obs_len = if_len2.len_rx;
         end
         3: begin
            obs_valid = if_sync.pck_valid; obs_err = if_sync.pck_err; obs_we = if_sync.we;
            obs_busy = if_sync.busy; obs_code = if_sync.err_code; obs_state = if_sync.state_dbg;
            obs_cmd = if_sync.cmd_rx; obs_wdata = if_sync.wr_data; obs_waddr = if_sync.wr_addr;
            obs_len = {8'h00, if_sync.len_rx};
         end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (sel %0d, t=%0t)", tag, got, exp, sel, $time);
   endtask

   // One cycle of stimulus, applied at a falling edge; outputs are sampled at
   // the next falling edge, i.e. one cycle after the strobe. Any write strobe
   // is matched against the expected-write queue.
   task automatic step(input logic rx, input logic [7:0] b, input logic ack, input logic tmo);
      rx_done = rx;
      rx_data = b;
      pck_ack = ack;
      timeout = tmo;
      @(negedge clk);
      rx_done = 1'b0;
      pck_ack = 1'b0;
      timeout = 1'b0;
      if (obs_we) begin
         if (exp_q.size() == 0) check("unexpected_we", {obs_waddr, obs_wdata}, 64'h0);
         else check("wr_addr_data", {obs_waddr, obs_wdata}, exp_q.pop_front());
      end
   endtask

   task automatic send(input logic [7:0] b);
      step(1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   // Stimulus and checks.
   initial begin
      repeat (3) @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         sel = s;
         #1;
         check("reset_outputs", {obs_valid, obs_err, obs_we, obs_busy, obs_code, obs_cmd, obs_wdata, obs_waddr, obs_len}, 64'h0);
         check("reset_state", obs_state, ST_IDLE);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Default config: good frame 74 03 5A 18 F0 26.
      sel = 0;
      exp_q = '{16'h005A, 16'h0118, 16'h02F0};
      send(8'h74);
      check("def_state_after_cmd", obs_state, ST_LEN_L);
      check("def_busy", obs_busy, 1'b1);
      send(8'h03);
      check("def_state_after_len", obs_state, ST_DATA);
      send(8'h5A);
      send(8'h18);
      send(8'hF0);
      check("def_writes_done", exp_q.size(), 0);
      check("def_state_chk", obs_state, ST_CHK);
      send(8'h26);
      check("def_valid", obs_valid, 1'b1);
      check("def_cmd", obs_cmd, 8'h74);
      check("def_len", obs_len, 16'd3);
      check("def_no_err", obs_err, 1'b0);
      // Overrun while holding.
      send(8'h33);
      check("ovr_err", {obs_err, obs_code}, {1'b1, ERR_OVR});
      check("ovr_valid_kept", obs_valid, 1'b1);
      check("ovr_cmd_kept", obs_cmd, 8'h74);
      check("ovr_state", obs_state, ST_HOLD);
      idle_cycles(1);
      check("ovr_err_pulse", {obs_err, obs_code}, {1'b0, ERR_OVR});
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("def_ack_valid", obs_valid, 1'b0);
      check("def_ack_state", obs_state, ST_IDLE);
      check("def_ack_busy", obs_busy, 1'b0);

      // Checksum error: last byte 27.
      exp_q = '{16'h005A, 16'h0118, 16'h02F0};
      send(8'h74); send(8'h03); send(8'h5A); send(8'h18); send(8'hF0);
      send(8'h27);
      check("chk_err", {obs_err, obs_code}, {1'b1, ERR_CHK});
      check("chk_err_valid", obs_valid, 1'b0);
      check("chk_err_state", obs_state, ST_IDLE);
      check("chk_err_writes", exp_q.size(), 0);

      // CRC-8 mode: 01 00 15 good, 01 00 14 bad.
      sel = 1;
      send(8'h01);
      send(8'h00);
      check("crc_zero_len_to_chk", obs_state, ST_CHK);
      send(8'h15);
      check("crc_valid", obs_valid, 1'b1);
      check("crc_cmd_len", {obs_cmd, obs_len}, {8'h01, 16'd0});
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("crc_ack", obs_valid, 1'b0);
      send(8'h01); send(8'h00); send(8'h14);
      check("crc_bad", {obs_err, obs_code, obs_valid}, {1'b1, ERR_CHK, 1'b0});

      // Two-byte length: 10 01 01 is 257 > 256.
      sel = 2;
      send(8'h10);
      check("len2_state_h", obs_state, ST_LEN_H);
      send(8'h01);
      check("len2_no_err_yet", obs_err, 1'b0);
      send(8'h01);
      check("len2_too_long", {obs_err, obs_code}, {1'b1, ERR_LEN});
      check("len2_state_idle", obs_state, ST_IDLE);
      exp_q = '{16'h00AA, 16'h01BB};
      send(8'h10); send(8'h00); send(8'h02); send(8'hAA); send(8'hBB);
      send(8'h88);
      check("len2_valid", obs_valid, 1'b1);
      check("len2_cmd_len", {obs_cmd, obs_len}, {8'h10, 16'h0002});
      check("len2_writes", exp_q.size(), 0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("len2_ack", obs_valid, 1'b0);

      // Sync mode: FF ignored, then A5 74 01 33 57.
      sel = 3;
      send(8'hFF);
      check("sync_ignore", {obs_busy, obs_err}, 2'b00);
      send(8'hA5);
      check("sync_to_cmd", obs_state, ST_CMD);
      exp_q = '{16'h0033};
      send(8'h74); send(8'h01); send(8'h33); send(8'h57);
      check("sync_valid", {obs_valid, obs_cmd, obs_len}, {1'b1, 8'h74, 16'd1});
      // Ack with a simultaneous sync byte restarts a frame.
      step(1'b1, 8'hA5, 1'b1, 1'b0);
      check("ack_sync_valid", obs_valid, 1'b0);
      check("ack_sync_state", obs_state, ST_CMD);
      exp_q = '{16'h0033};
      send(8'h74); send(8'h01); send(8'h33); send(8'h57);
      check("restart_valid", obs_valid, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      // Timeout after the data byte.
      exp_q = '{16'h0033};
      send(8'hA5); send(8'h74); send(8'h01); send(8'h33);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("tmo_err", {obs_err, obs_code}, {1'b1, ERR_TMO});
      check("tmo_state", obs_state, ST_IDLE);
      // Timeout together with a data byte: byte dropped, no write.
      send(8'hA5); send(8'h74); send(8'h01);
      step(1'b1, 8'h33, 1'b0, 1'b1);
      check("tmo_wins", {obs_err, obs_code, obs_we}, {1'b1, ERR_TMO, 1'b0});
      // Timeout ignored in IDLE.
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("tmo_idle_ignored", obs_err, 1'b0);
      exp_q = '{16'h0033};
      send(8'hA5); send(8'h74); send(8'h01); send(8'h33); send(8'h57);
      check("after_tmo_valid", {obs_valid, obs_err}, 2'b10);
      check("after_tmo_writes", exp_q.size(), 0);

      // Asynchronous reset in the middle of a payload.
      sel = 0;
      exp_q = '{16'h005A, 16'h0118};
      send(8'h74); send(8'h03); send(8'h5A); send(8'h18);
      check("pre_reset_we", obs_we, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("async_reset_outputs", {obs_valid, obs_err, obs_we, obs_busy, obs_code, obs_cmd, obs_wdata, obs_waddr, obs_len}, 64'h0);
      check("async_reset_state", obs_state, ST_IDLE);
      sel = 3;
      #1;
      check("async_reset_sync_inst", {obs_valid, obs_cmd, obs_len}, 64'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
